// File: rtl/am_lock_rx.sv
// Per-lane 40GBASE-R alignment-marker lock: finds the lane marker, checks it every
// AM_GAP_N+1 valid blocks and flags confirmed markers to deskew with one cycle of latency.
module am_lock_rx #(
    parameter int unsigned BLOCK_W  = 66,
    parameter int unsigned LANE_N   = 4,
    parameter int unsigned AM_GAP_N = 16383,
    parameter int unsigned INV_N    = 4
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  valid_i,
    input  logic                                  block_lock_v_i,
    input  logic [BLOCK_W-1:0]                    data_i,
    output logic                                  valid_o,
    output logic [BLOCK_W-1:0]                    data_o,
    output logic                                  am_lite_v_o,
    output logic                                  am_lite_lock_v_o,
    output logic [$clog2(LANE_N)-1:0]             lane_o
);

    localparam int unsigned LANE_W = $clog2(LANE_N);
    localparam int unsigned CNT_W  = $clog2(AM_GAP_N + 1);
    localparam int unsigned INV_W  = $clog2(INV_N + 1);

    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(AM_GAP_N);
    localparam logic [INV_W-1:0] INV_LAST = INV_W'(INV_N - 1);

    typedef enum logic [1:0] {
        StSearch,
        StCheck,
        StLocked
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    blk_cnt_q, blk_cnt_d;
    logic [INV_W-1:0]    inv_cnt_q, inv_cnt_d;
    logic [LANE_W-1:0]   lane_q, lane_d;
    logic                am_v_d;

    logic [LANE_N-1:0]   lane_hit;
    logic                any_hit;
    logic [LANE_W-1:0]   hit_lane;
    logic                slot;
    logic                own_hit;

    // {[55:32],[23:0]} of each lane's marker; BIP bytes are excluded.
    function automatic logic [47:0] am_pattern(input int unsigned lane);
        case (lane)
            0:       am_pattern = 48'hb8896f_477690;
            1:       am_pattern = 48'h193b0f_e6c4f0;
            2:       am_pattern = 48'h649a3a_9b65c5;
            3:       am_pattern = 48'hc2865d_3d79a2;
            default: am_pattern = 48'h0;
        endcase
    endfunction

    function automatic logic is_marker(input logic [BLOCK_W-1:0] blk, input int unsigned lane);
        logic [47:0] pat;
        pat = am_pattern(lane);
        is_marker = (lane < 4) && (blk[65:64] == 2'b10) &&
                    (blk[55:32] == pat[47:24]) && (blk[23:0] == pat[23:0]);
    endfunction

    always_comb begin
        lane_hit = '0;
        for (int unsigned i = 0; i < LANE_N; i++) begin
            lane_hit[i] = is_marker(data_i, i);
        end
    end

    // Lowest-numbered hit wins; the patterns are distinct so at most one fires.
    always_comb begin
        hit_lane = '0;
        for (int i = LANE_N - 1; i >= 0; i--) begin
            if (lane_hit[i]) begin
                hit_lane = LANE_W'(i);
            end
        end
    end

    assign any_hit = |lane_hit;
    assign own_hit = lane_hit[lane_q];
    assign slot    = (blk_cnt_q == GAP_LAST);

    always_comb begin
        state_d   = state_q;
        blk_cnt_d = blk_cnt_q;
        inv_cnt_d = inv_cnt_q;
        lane_d    = lane_q;
        am_v_d    = 1'b0;

        if (!block_lock_v_i) begin
            state_d   = StSearch;
            blk_cnt_d = '0;
            inv_cnt_d = '0;
        end else if (valid_i) begin
            unique case (state_q)
                StSearch: begin
                    if (any_hit) begin
                        lane_d    = hit_lane;
                        blk_cnt_d = '0;
                        state_d   = StCheck;
                    end
                end
                StCheck: begin
                    if (slot) begin
                        blk_cnt_d = '0;
                        if (own_hit) begin
                            state_d   = StLocked;
                            inv_cnt_d = '0;
                            am_v_d    = 1'b1;
                        end else begin
                            state_d = StSearch;
                        end
                    end else begin
                        blk_cnt_d = blk_cnt_q + CNT_W'(1);
                    end
                end
                StLocked: begin
                    if (slot) begin
                        blk_cnt_d = '0;
                        if (own_hit) begin
                            inv_cnt_d = '0;
                            am_v_d    = 1'b1;
                        end else if (inv_cnt_q == INV_LAST) begin
                            inv_cnt_d = '0;
                            state_d   = StSearch;
                        end else begin
                            inv_cnt_d = inv_cnt_q + INV_W'(1);
                        end
                    end else begin
                        blk_cnt_d = blk_cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = StSearch;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= StSearch;
            blk_cnt_q        <= '0;
            inv_cnt_q        <= '0;
            lane_q           <= '0;
            valid_o          <= 1'b0;
            data_o           <= '0;
            am_lite_v_o      <= 1'b0;
            am_lite_lock_v_o <= 1'b0;
        end else begin
            state_q          <= state_d;
            blk_cnt_q        <= blk_cnt_d;
            inv_cnt_q        <= inv_cnt_d;
            lane_q           <= lane_d;
            valid_o          <= valid_i;
            data_o           <= data_i;
            am_lite_v_o      <= am_v_d;
            // Lock reflects the state the block was evaluated in, gated by block lock.
            am_lite_lock_v_o <= block_lock_v_i && (state_q == StLocked);
        end
    end

    assign lane_o = lane_q;

endmodule
